// File: rtl/dcache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int NUM_LINES      = 16;
    localparam int WORDS_PER_LINE = 4;

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {
        ST_COMPARE   = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage for dcache_ctrl: valid/dirty/tag/data with async read, sync write,
// and a sync active-low clear of the valid and dirty bits.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] idx,
    input  logic [OFF_W-1:0] rd_off,
    input  logic [OFF_W-1:0] wb_off,
    output logic             line_valid,
    output logic             line_dirty,
    output logic [TAG_W-1:0] line_tag,
    output logic [31:0]      rd_word,
    output logic [31:0]      wb_word,
    input  logic             word_we,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic             set_dirty,
    input  logic             fill_done,
    input  logic [TAG_W-1:0] fill_tag
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

    assign line_valid = valid_q[idx];
    assign line_dirty = dirty_q[idx];
    assign line_tag   = tag_q[idx];
    assign rd_word    = data_q[idx][rd_off];
    assign wb_word    = data_q[idx][wb_off];

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (set_dirty) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data are only meaningful behind valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[idx] <= fill_tag;
        end
        if (word_we) begin
            data_q[idx][wr_off] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller (MEM stage to DataMemory).
// Optional macro DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    state_t           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_addr_bits;

    logic             line_valid, line_dirty;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      rd_word, wb_word;
    logic             word_we, set_dirty, fill_done;
    logic [OFF_W-1:0] wr_off;
    logic [31:0]      wr_data;
    logic             hit, cnt_last;

    assign req_off          = req_addr[OFF_W+1:2];
    assign req_idx          = req_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign req_tag          = req_addr[31:IDX_W+OFF_W+2];
    assign unused_addr_bits = ^req_addr[1:0];

    assign hit      = req_valid & line_valid & (line_tag == req_tag);
    assign cnt_last = (cnt_q == {OFF_W{1'b1}});
    assign rdata    = rd_word;
    assign mem_din  = wb_word;

    dcache_line_array u_lines (
        .clk        (clk),
        .reset      (reset),
        .idx        (req_idx),
        .rd_off     (req_off),
        .wb_off     (cnt_q),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .rd_word    (rd_word),
        .wb_word    (wb_word),
        .word_we    (word_we),
        .wr_off     (wr_off),
        .wr_data    (wr_data),
        .set_dirty  (set_dirty),
        .fill_done  (fill_done),
        .fill_tag   (req_tag)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_COMPARE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = {req_tag, req_idx, req_off, 2'b00};
        word_we   = 1'b0;
        wr_off    = req_off;
        wr_data   = req_wdata;
        set_dirty = 1'b0;
        fill_done = 1'b0;
        case (state_q)
            ST_COMPARE: begin
                ready = hit;
                if (hit && req_write) begin
                    word_we   = 1'b1;
                    set_dirty = 1'b1;
                end else if (req_valid && !hit) begin
                    state_d = (line_valid && line_dirty) ? ST_WRITEBACK : ST_REFILL;
                    cnt_d   = '0;
                end
            end
            ST_WRITEBACK: begin
                mem_write = 1'b1;
                mem_addr  = {line_tag, req_idx, cnt_q, 2'b00};
                if (cnt_last) begin
                    state_d = ST_REFILL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REFILL: begin
                mem_read = 1'b1;
                mem_addr = {req_tag, req_idx, cnt_q, 2'b00};
                word_we  = 1'b1;
                wr_off   = cnt_q;
                wr_data  = mem_dout;
                if (cnt_last) begin
                    fill_done = 1'b1;
                    state_d   = ST_COMPARE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_COMPARE;
        endcase
        // Gating in the reset cycle keeps a half-finished write-back from committing a word.
        if (!reset) begin
            ready     = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            word_we   = 1'b0;
            set_dirty = 1'b0;
            fill_done = 1'b0;
        end
    end

`ifdef DCACHE_STATS_EN
    logic miss_pend_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // miss_pend_q marks the COMPARE cycle that retires a miss, so it is not recounted as a hit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            miss_pend_q <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else if (state_q == ST_COMPARE) begin
            if (req_valid && !miss_pend_q) begin
                if (hit) hit_count  <= sat_inc(hit_count);
                else     miss_count <= sat_inc(miss_count);
            end
            miss_pend_q <= req_valid && !hit;
        end
    end
`endif

endmodule
